// File: rtl/io_bus_master_pkg.sv
// Shared definitions for the io_* peripheral bus: FSM states, bus widths
// and the IO hub register map.
package io_bus_pkg;

  localparam int IO_DW = 16;
  localparam int IO_AW = 16;

  localparam logic [IO_AW-1:0] IO_CTRL0_ADDR  = 16'd0;
  localparam logic [IO_AW-1:0] IO_CTRL0_FLAGS = 16'd2;
  localparam logic [IO_AW-1:0] IO_CTRL1_DATA  = 16'd4;
  localparam logic [IO_AW-1:0] IO_CTRL1_FIN   = 16'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } state_e;

  // The hub only decodes 16-bit registers, so any odd byte address is rejected.
  function automatic logic isMisaligned(input logic [IO_AW-1:0] addr);
    return (addr & IO_AW'(1)) != '0;
  endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// Core request/response handshake plus io_* bus signals of io_bus_master.
interface io_bus_master_if;
  import io_bus_pkg::*;

  logic             req_i;
  logic             req_we_i;
  logic [IO_AW-1:0] req_addr_i;
  logic [IO_DW-1:0] req_dat_i;
  logic             req_rdy_o;
  logic             rsp_vld_o;
  logic [IO_DW-1:0] rsp_dat_o;
  logic             rsp_err_o;
  logic             io_stb_o;
  logic             io_we_o;
  logic [IO_AW-1:0] io_addr_o;
  logic [IO_DW-1:0] io_dat_o;
  logic [IO_DW-1:0] io_dat_i;
  logic             io_ack_i;

  modport master (
    input  req_i, req_we_i, req_addr_i, req_dat_i, io_dat_i, io_ack_i,
    output req_rdy_o, rsp_vld_o, rsp_dat_o, rsp_err_o,
           io_stb_o, io_we_o, io_addr_o, io_dat_o
  );

  modport slave (
    output req_i, req_we_i, req_addr_i, req_dat_i, io_dat_i, io_ack_i,
    input  req_rdy_o, rsp_vld_o, rsp_dat_o, rsp_err_o,
           io_stb_o, io_we_o, io_addr_o, io_dat_o
  );

endinterface

// File: rtl/io_bus_master.sv
// CPU-side initiator for the io_* bus: one access at a time, with
// misalignment and ack-timeout errors reported in the response.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  io_bus_master_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [IO_AW-1:0] addr_q, addr_d;
  logic [IO_DW-1:0] dat_q, dat_d;
  logic             rspVld_q, rspVld_d;
  logic [IO_DW-1:0] rspDat_q, rspDat_d;
  logic             rspErr_q, rspErr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Outputs are computed alongside the next state so they can all be registered.
  always_comb begin
    state_d  = state_q;
    stb_d    = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    dat_d    = dat_q;
    rspVld_d = 1'b0;
    rspDat_d = rspDat_q;
    rspErr_d = rspErr_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE, RESP: begin
        if (bus.req_i) begin
          if (isMisaligned(bus.req_addr_i)) begin
            state_d = ERR;
          end else begin
            state_d = BUS;
            stb_d   = 1'b1;
            we_d    = bus.req_we_i;
            addr_d  = bus.req_addr_i;
            dat_d   = bus.req_dat_i;
            cnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (bus.io_ack_i) begin
          state_d  = RESP;
          rspVld_d = 1'b1;
          rspDat_d = we_q ? '0 : bus.io_dat_i;
          rspErr_d = 1'b0;
          we_d     = 1'b0;
        end else if (cnt_q == CntMax) begin
          state_d  = RESP;
          rspVld_d = 1'b1;
          rspDat_d = '0;
          rspErr_d = 1'b1;
          we_d     = 1'b0;
        end else begin
          stb_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        state_d  = RESP;
        rspVld_d = 1'b1;
        rspDat_d = '0;
        rspErr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      rspVld_q <= 1'b0;
      rspDat_q <= '0;
      rspErr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      rspVld_q <= rspVld_d;
      rspDat_q <= rspDat_d;
      rspErr_q <= rspErr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_rdy_o = (state_q == IDLE) || (state_q == RESP);
  assign bus.rsp_vld_o = rspVld_q;
  assign bus.rsp_dat_o = rspDat_q;
  assign bus.rsp_err_o = rspErr_q;
  assign bus.io_stb_o  = stb_q;
  assign bus.io_we_o   = we_q & stb_q;
  assign bus.io_addr_o = addr_q;
  assign bus.io_dat_o  = dat_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed self-checking bench for io_bus_master with a simple responder
// whose ack delay and read data are set per test.
module tb_io_bus_master;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int          passCount = 0;
  int          checkCount = 0;
  int          ackDelay = 0;
  logic        ackNever = 1'b0;
  logic        rdEcho = 1'b0;
  logic [15:0] rdData = 16'h0000;
  int          stbCycles = 0;

  io_bus_master_if bus();

  io_bus_master #(.TIMEOUT(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Responder: ack after ackDelay completed strobe cycles, combinational from io_stb_o.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stbCycles <= 0;
    else if (bus.io_stb_o && !bus.io_ack_i)
      stbCycles <= stbCycles + 1;
    else
      stbCycles <= 0;
  end

  assign bus.io_ack_i = bus.io_stb_o && !ackNever && (stbCycles == ackDelay);
  assign bus.io_dat_i = rdEcho ? (16'hD000 | bus.io_addr_o) : rdData;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Issue one request and watch the bus until the response (bounded).
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                               output int stbCnt, output int lat, output logic err,
                               output logic [15:0] rdat, output logic fWe,
                               output logic [15:0] fAddr, output logic [15:0] fDat,
                               output logic stable);
    stbCnt = 0; lat = -1; err = 1'b0; rdat = '0;
    fWe = 1'b0; fAddr = '0; fDat = '0; stable = 1'b1;
    @(negedge clk_i);
    for (int k = 0; k < 20 && !bus.req_rdy_o; k++) @(negedge clk_i);
    bus.req_i = 1'b1; bus.req_we_i = w; bus.req_addr_i = a; bus.req_dat_i = d;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.io_stb_o) begin
        if (stbCnt == 0) begin
          fWe = bus.io_we_o; fAddr = bus.io_addr_o; fDat = bus.io_dat_o;
        end else if (bus.io_addr_o !== fAddr) begin
          stable = 1'b0;
        end
        stbCnt++;
      end
      if (bus.rsp_vld_o) begin
        lat = k; err = bus.rsp_err_o; rdat = bus.rsp_dat_o;
        break;
      end
      if (k < 40) @(negedge clk_i);
    end
  endtask

  int          stbCnt, lat, accT[4], vldT[4], idx, nv, t;
  logic        err, fWe, stable, accNow;
  logic [15:0] rdat, fAddr, fDat, vldD[4], vldE;
  logic [15:0] b2bAddr[4];

  initial begin
    b2bAddr[0] = 16'd0; b2bAddr[1] = 16'd2; b2bAddr[2] = 16'd4; b2bAddr[3] = 16'd6;
    bus.req_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0; bus.req_dat_i = '0;

    #1;
    checkOutput("resetStb", {31'd0, bus.io_stb_o}, 32'd0);
    checkOutput("resetWe", {31'd0, bus.io_we_o}, 32'd0);
    checkOutput("resetVld", {31'd0, bus.rsp_vld_o}, 32'd0);
    checkOutput("resetErr", {31'd0, bus.rsp_err_o}, 32'd0);
    checkOutput("resetRspDat", {16'd0, bus.rsp_dat_o}, 32'd0);
    checkOutput("resetAddr", {16'd0, bus.io_addr_o}, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("rdyAfterReset", {31'd0, bus.req_rdy_o}, 32'd1);

    $display("[TB] write 0x0100 to addr 2, combinational ack");
    ackDelay = 0; ackNever = 1'b0;
    applyStimulus(1'b1, 16'd2, 16'h0100, stbCnt, lat, err, rdat, fWe, fAddr, fDat, stable);
    checkOutput("wrStbCycles", stbCnt, 32'd1);
    checkOutput("wrWe", {31'd0, fWe}, 32'd1);
    checkOutput("wrAddr", {16'd0, fAddr}, 32'd2);
    checkOutput("wrDat", {16'd0, fDat}, 32'h0100);
    checkOutput("wrLatency", lat, 32'd2);
    checkOutput("wrErr", {31'd0, err}, 32'd0);
    checkOutput("wrRspDat", {16'd0, rdat}, 32'd0);
    @(negedge clk_i);
    checkOutput("wrVldOneCycle", {31'd0, bus.rsp_vld_o}, 32'd0);

    $display("[TB] read addr 4, ack after 3 wait cycles");
    ackDelay = 3; rdData = 16'hA5C3;
    applyStimulus(1'b0, 16'd4, 16'h0000, stbCnt, lat, err, rdat, fWe, fAddr, fDat, stable);
    checkOutput("rdStbCycles", stbCnt, 32'd4);
    checkOutput("rdWe", {31'd0, fWe}, 32'd0);
    checkOutput("rdAddr", {16'd0, fAddr}, 32'd4);
    checkOutput("rdAddrStable", {31'd0, stable}, 32'd1);
    checkOutput("rdLatency", lat, 32'd5);
    checkOutput("rdData", {16'd0, rdat}, 32'hA5C3);
    checkOutput("rdErr", {31'd0, err}, 32'd0);

    $display("[TB] read addr 6, no ack");
    ackNever = 1'b1;
    applyStimulus(1'b0, 16'd6, 16'h0000, stbCnt, lat, err, rdat, fWe, fAddr, fDat, stable);
    checkOutput("toStbCycles", stbCnt, 32'd16);
    checkOutput("toLatency", lat, 32'd17);
    checkOutput("toErr", {31'd0, err}, 32'd1);
    checkOutput("toRspDat", {16'd0, rdat}, 32'd0);

    $display("[TB] read addr 6, ack in 16th strobe cycle");
    ackNever = 1'b0; ackDelay = 15; rdData = 16'h1234;
    applyStimulus(1'b0, 16'd6, 16'h0000, stbCnt, lat, err, rdat, fWe, fAddr, fDat, stable);
    checkOutput("lateAckStbCycles", stbCnt, 32'd16);
    checkOutput("lateAckErr", {31'd0, err}, 32'd0);
    checkOutput("lateAckData", {16'd0, rdat}, 32'h1234);

    $display("[TB] misaligned request to addr 3");
    ackDelay = 0;
    applyStimulus(1'b1, 16'd3, 16'hBEEF, stbCnt, lat, err, rdat, fWe, fAddr, fDat, stable);
    checkOutput("misStbCycles", stbCnt, 32'd0);
    checkOutput("misLatency", lat, 32'd2);
    checkOutput("misErr", {31'd0, err}, 32'd1);
    checkOutput("misRspDat", {16'd0, rdat}, 32'd0);

    $display("[TB] back-to-back reads of addr 0,2,4,6");
    rdEcho = 1'b1; ackDelay = 0;
    for (int i = 0; i < 4; i++) begin accT[i] = -1; vldT[i] = -1; vldD[i] = '0; end
    vldE = '0; idx = 0; nv = 0; t = 0;
    @(negedge clk_i);
    bus.req_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = b2bAddr[0];
    while (t < 40 && nv < 4) begin
      if (bus.rsp_vld_o) begin
        vldT[nv] = t; vldD[nv] = bus.rsp_dat_o; vldE[nv] = bus.rsp_err_o;
        nv++;
      end
      accNow = bus.req_i && bus.req_rdy_o;
      if (accNow && idx < 4) accT[idx] = t;
      @(negedge clk_i);
      t++;
      if (accNow && idx < 4) begin
        idx++;
        if (idx < 4) bus.req_addr_i = b2bAddr[idx];
        else bus.req_i = 1'b0;
      end
    end
    bus.req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("b2bAccept%0d", i), accT[i], 2 * i);
      checkOutput($sformatf("b2bVldTime%0d", i), vldT[i], 2 * i + 2);
      checkOutput($sformatf("b2bData%0d", i), {16'd0, vldD[i]}, {16'd0, 16'hD000 | b2bAddr[i]});
      checkOutput($sformatf("b2bErr%0d", i), {31'd0, vldE[i]}, 32'd0);
    end
    rdEcho = 1'b0;

    $display("[TB] reset during a bus cycle");
    ackNever = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    bus.req_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 16'd4; bus.req_dat_i = 16'h5555;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("preResetStb", {31'd0, bus.io_stb_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("midResetStb", {31'd0, bus.io_stb_o}, 32'd0);
    checkOutput("midResetWe", {31'd0, bus.io_we_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    ackNever = 1'b0;
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (bus.rsp_vld_o) nv++;
    end
    checkOutput("noRspAfterReset", nv, 32'd0);
    checkOutput("rdyAfterMidReset", {31'd0, bus.req_rdy_o}, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
